// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for FIFO drain controllers: FSM state encoding and a
// reusable round-robin pick function (supports up to 16 requesters).
package fifo_ctrl_pkg;

  typedef enum logic [0:0] {IDLE, BURST} state_t;

  localparam int unsigned RR_MAX_N = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0] searching upward from ptr, wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req,
                                       input logic [3:0]          ptr,
                                       input int unsigned         n);
    rr_pick_t    r;
    int unsigned i;
    r = '0;
    for (int unsigned off = 0; off < RR_MAX_N; off++) begin
      if (off < n) begin
        i = (32'(ptr) + off) % n;
        if (!r.found && req[i[3:0]]) begin
          r.found = 1'b1;
          r.idx   = i[3:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority search over N requesters starting at ptr.
module rr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] idx,
  output logic          found
);

  rr_pick_t pick;

  always_comb begin
    pick  = rr_pick(RR_MAX_N'(req), 4'(ptr), N);
    idx   = SW'(pick.idx);
    found = pick.found;
  end

endmodule

// File: rtl/fifo_drain_arb.sv
// Round-robin drain of N show-ahead FIFOs into one registered valid/ready stream,
// granting one channel at a time for bursts of up to MAX_BURST words.
module fifo_drain_arb
  import fifo_ctrl_pkg::*;
#(
  parameter  int unsigned N         = 4,
  parameter  int unsigned DW        = 8,
  parameter  int unsigned AW        = 10,
  parameter  int unsigned MAX_BURST = 16,
  localparam int unsigned SW        = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    ch_en,
  input  logic [N*AW-1:0] fifo_cnt,
  input  logic [N*DW-1:0] fifo_dout,
  output logic [N-1:0]    fifo_read,
  output logic [DW-1:0]   m_data,
  output logic [SW-1:0]   m_src,
  output logic            m_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            busy
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  state_t        state_q, state_d;
  logic [SW-1:0] grant_q, grant_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic [SW-1:0] m_src_q, m_src_d;
  logic          m_last_q, m_last_d;
  logic          m_valid_q, m_valid_d;

  logic [N-1:0]  req;
  logic [SW-1:0] pick_idx;
  logic          pick_found;
  logic [AW-1:0] cnt_g;
  logic [DW-1:0] dout_g;
  logic [SW-1:0] grant_inc;
  logic          is_last;
  logic          pop;

  always_comb begin
    req    = '0;
    cnt_g  = '0;
    dout_g = '0;
    for (int unsigned i = 0; i < N; i++) begin
      req[i] = ch_en[i] && (fifo_cnt[i*AW +: AW] != '0);
      if (grant_q == SW'(i)) begin
        cnt_g  = fifo_cnt[i*AW +: AW];
        dout_g = fifo_dout[i*DW +: DW];
      end
    end
  end

  rr_arbiter #(.N(N)) u_rr_arbiter (
    .req   (req),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Pointer wraps modulo N so non-power-of-two channel counts never select a ghost index.
  assign grant_inc = (grant_q == SW'(N - 1)) ? '0 : grant_q + SW'(1);
  assign is_last   = (beat_cnt_q == BW'(MAX_BURST - 1)) || (cnt_g == AW'(1));

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    m_data_d   = m_data_q;
    m_src_d    = m_src_q;
    m_last_d   = m_last_q;
    m_valid_d  = m_valid_q;
    pop        = 1'b0;
    fifo_read  = '0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        // An emptied granted FIFO (external flush) abandons the burst without a pop.
        if (cnt_g == '0) begin
          state_d  = IDLE;
          rr_ptr_d = grant_inc;
        end else if (!m_valid_q || m_ready) begin
          pop        = 1'b1;
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (is_last) begin
            state_d  = IDLE;
            rr_ptr_d = grant_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    for (int unsigned i = 0; i < N; i++) begin
      fifo_read[i] = pop && (grant_q == SW'(i));
    end

    if (pop) begin
      m_data_d  = dout_g;
      m_src_d   = grant_q;
      m_last_d  = is_last;
      m_valid_d = 1'b1;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      m_data_q   <= '0;
      m_src_q    <= '0;
      m_last_q   <= 1'b0;
      m_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      m_data_q   <= m_data_d;
      m_src_q    <= m_src_d;
      m_last_q   <= m_last_d;
      m_valid_q  <= m_valid_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_src   = m_src_q;
  assign m_last  = m_last_q;
  assign m_valid = m_valid_q;
  assign busy    = (state_q == BURST);

endmodule

// File: tb/tb_fifo_drain_arb.sv
// Self-checking bench for fifo_drain_arb: behavioural FIFO models, a data scoreboard
// and an independent round-robin order predictor.
module tb_fifo_drain_arb;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int MB = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    ch_en;
  logic [N*AW-1:0] fifo_cnt;
  logic [N*DW-1:0] fifo_dout;
  logic [N-1:0]    fifo_read;
  logic [DW-1:0]   m_data;
  logic [1:0]      m_src;
  logic            m_last;
  logic            m_valid;
  logic            m_ready;
  logic            busy;

  always #5 clk = ~clk;

  fifo_drain_arb #(.N(N), .DW(DW), .AW(AW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_en     (ch_en),
    .fifo_cnt  (fifo_cnt),
    .fifo_dout (fifo_dout),
    .fifo_read (fifo_read),
    .m_data    (m_data),
    .m_src     (m_src),
    .m_last    (m_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .busy      (busy)
  );

  typedef struct { logic [DW-1:0] data; logic [1:0] src; } sb_t;
  typedef struct { logic [1:0] src; logic last; } ord_t;
  typedef struct {
    logic [3:0] en;
    int c0, c1, c2, c3;
    int rm;
    int words;
    int lasts;
  } vec_t;

  logic [DW-1:0] fq [N][$];
  sb_t           sb [$];
  ord_t          exp_q [$];

  int n_checks = 0, n_fail = 0;
  int n_acc, n_last, pops_total, cyc, rmode;
  logic [N-1:0]  rd_pending;
  logic          prev_stall;
  logic [DW-1:0] h_data;
  logic [1:0]    h_src;
  logic          h_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_ports();
    for (int i = 0; i < N; i++) begin
      fifo_cnt[i*AW +: AW]  = AW'(fq[i].size());
      fifo_dout[i*DW +: DW] = (fq[i].size() > 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic load(input int ch, input int n);
    int base;
    base = fq[ch].size();
    for (int k = 0; k < n; k++) fq[ch].push_back(DW'(ch * 64 + base + k));
    set_ports();
  endtask

  task automatic push_burst(input int src, input int len);
    ord_t o;
    for (int k = 0; k < len; k++) begin
      o.src  = 2'(src);
      o.last = (k == len - 1);
      exp_q.push_back(o);
    end
  endtask

  // Order model: grant from pointer upward, burst = min(MB, count), pointer -> grant+1.
  task automatic predict(input logic [3:0] en, input int a0, input int a1, input int a2, input int a3);
    int c[N];
    int ptr, g, len;
    c[0] = a0; c[1] = a1; c[2] = a2; c[3] = a3;
    ptr = 0;
    forever begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && en[(ptr + k) % N] && c[(ptr + k) % N] > 0) g = (ptr + k) % N;
      end
      if (g < 0) break;
      len = (c[g] < MB) ? c[g] : MB;
      push_burst(g, len);
      c[g] -= len;
      ptr = (g + 1) % N;
    end
  endtask

  task automatic monitor();
    sb_t  s;
    ord_t o;
    if (!rst_n) begin
      rd_pending = '0;
      prev_stall = 1'b0;
      return;
    end
    check("onehot_read", 32'($countones(fifo_read) <= 1), 1);
    if (prev_stall) check("stall_hold", {m_valid, m_data, m_src, m_last}, {1'b1, h_data, h_src, h_last});
    prev_stall = m_valid && !m_ready;
    if (prev_stall) begin
      check("stall_noread", 32'(fifo_read), 0);
      h_data = m_data; h_src = m_src; h_last = m_last;
    end
    rd_pending = fifo_read;
    for (int i = 0; i < N; i++) begin
      if (fifo_read[i]) begin
        pops_total++;
        if (fq[i].size() == 0) check("pop_nonempty", 0, 1);
        else begin
          s.data = fq[i][0];
          s.src  = 2'(i);
          sb.push_back(s);
        end
      end
    end
    if (m_valid && m_ready) begin
      n_acc++;
      if (m_last) n_last++;
      if (sb.size() == 0) check("sb_underflow", 0, 1);
      else begin
        s = sb.pop_front();
        check("data", 32'(m_data), 32'(s.data));
        check("src", 32'(m_src), 32'(s.src));
      end
      if (exp_q.size() == 0) check("order_underflow", 0, 1);
      else begin
        o = exp_q.pop_front();
        check("order_src", 32'(m_src), 32'(o.src));
        check("last", 32'(m_last), 32'(o.last));
      end
    end
  endtask

  // One clock: sample at negedge, apply FIFO pops just after posedge, then drive m_ready.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rd_pending[i] && fq[i].size() > 0) fq[i].delete(0);
    end
    rd_pending = '0;
    set_ports();
    #1;
    cyc++;
    case (rmode)
      1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b1;
    endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_outputs", {m_valid, m_data, m_src, m_last, fifo_read, busy}, 0);
    for (int i = 0; i < N; i++) fq[i].delete();
    sb.delete();
    exp_q.delete();
    n_acc = 0; n_last = 0; pops_total = 0;
    prev_stall = 1'b0; rd_pending = '0;
    set_ports();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_until(input int target, input int bound);
    int k;
    k = 0;
    while ((n_acc < target || busy) && k < bound) begin
      step();
      k++;
    end
    check("run_timeout", 32'(k < bound), 1);
  endtask

  task automatic wait_pops(input int target);
    int k;
    k = 0;
    while (pops_total < target && k < 200) begin
      step();
      k++;
    end
    check("pop_timeout", 32'(k < 200), 1);
  endtask

  vec_t vt[7];

  initial begin
    ch_en = 4'hF; m_ready = 1'b1; rmode = 0; cyc = 0;
    fifo_cnt = '0; fifo_dout = '0;
    rst_n = 1'b1;

    vt[0] = '{en: 4'hF, c0: 0,  c1: 0,  c2: 3,  c3: 0,  rm: 0, words: 3,  lasts: 1};
    vt[1] = '{en: 4'hF, c0: 20, c1: 20, c2: 20, c3: 20, rm: 0, words: 80, lasts: 8};
    vt[2] = '{en: 4'hF, c0: 10, c1: 0,  c2: 0,  c3: 0,  rm: 1, words: 10, lasts: 1};
    vt[3] = '{en: 4'hA, c0: 20, c1: 20, c2: 20, c3: 20, rm: 0, words: 40, lasts: 4};
    vt[4] = '{en: 4'hF, c0: 1,  c1: 1,  c2: 1,  c3: 1,  rm: 2, words: 4,  lasts: 4};
    vt[5] = '{en: 4'h5, c0: 5,  c1: 17, c2: 40, c3: 3,  rm: 2, words: 45, lasts: 4};
    vt[6] = '{en: 4'h0, c0: 3,  c1: 3,  c2: 3,  c3: 3,  rm: 0, words: 0,  lasts: 0};

    for (int v = 0; v < 7; v++) begin
      rmode = 0;
      do_reset();
      rmode = vt[v].rm;
      ch_en = vt[v].en;
      load(0, vt[v].c0); load(1, vt[v].c1); load(2, vt[v].c2); load(3, vt[v].c3);
      predict(vt[v].en, vt[v].c0, vt[v].c1, vt[v].c2, vt[v].c3);
      run_until(vt[v].words, 3000);
      repeat (5) step();
      check("vec_words", 32'(n_acc), 32'(vt[v].words));
      check("vec_lasts", 32'(n_last), 32'(vt[v].lasts));
      check("vec_exp_left", 32'(exp_q.size()), 0);
      check("vec_sb_left", 32'(sb.size()), 0);
      check("vec_idle", 32'(busy), 0);
    end
    check("disabled_untouched", 32'(fq[0].size()), 3);

    // Latency: request at t, fifo_read at t+1, m_valid at t+2.
    rmode = 0; ch_en = 4'hF;
    do_reset();
    load(2, 3);
    push_burst(2, 3);
    step();
    check("lat_read", {busy, m_valid, fifo_read}, {1'b1, 1'b0, 4'b0100});
    step();
    check("lat_valid", {m_valid, m_src, m_data}, {1'b1, 2'd2, 8'd128});
    run_until(3, 100);
    check("lat_lasts", 32'(n_last), 1);

    // Async reset mid-burst; the popped-but-held word is dropped, the rest stays queued.
    do_reset();
    load(1, 2);
    push_burst(1, 2);
    run_until(2, 100);
    load(0, 10);
    push_burst(0, 10);
    wait_pops(7);
    load(3, 3);
    rst_n = 1'b0;
    #1;
    check("async_reset", {m_valid, m_data, m_src, m_last, fifo_read, busy}, 0);
    sb.delete(); exp_q.delete();
    n_acc = 0; n_last = 0;
    check("reset_keeps_fifo", 32'(fq[0].size()), 5);
    step();
    rst_n = 1'b1;
    push_burst(0, 5);
    push_burst(3, 3);
    run_until(8, 200);
    check("rst_resume_lasts", 32'(n_last), 2);

    // Late single-word arrival on channel 3 is served before channel 0 again.
    do_reset();
    load(0, 20);
    push_burst(0, 16); push_burst(3, 1); push_burst(0, 4);
    wait_pops(3);
    load(3, 1);
    run_until(21, 400);
    check("late_arrival_lasts", 32'(n_last), 3);

    // Disabling the granted channel mid-burst lets its burst finish but blocks regrant.
    do_reset();
    ch_en = 4'b1010;
    for (int i = 0; i < N; i++) load(i, 20);
    push_burst(1, 16); push_burst(3, 16); push_burst(3, 4);
    wait_pops(2);
    ch_en = 4'b1000;
    run_until(36, 400);
    repeat (10) step();
    check("en_clear_words", 32'(n_acc), 36);
    check("en_clear_idle", 32'(busy), 0);
    check("en_clear_left", 32'(fq[1].size()), 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
